// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one registered (one-cycle latency) ALU between two requesters:
//   req0 = execute unit, req1 = address/PC unit. Round-robin on ties, one
//   transaction in flight. Sequence: IDLE -> ISSUE -> CAPT -> RESP -> IDLE.
//
//   Optional build macro: ALU_ARB_FLAGS_EN adds rsp_zero / rsp_sign outputs
//   captured alongside rsp_data.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          per-requester handshake (ready only in IDLE)
//   reqN_op/a/b               opcode and operands, held stable until ready
//   rsp0_valid, rsp1_valid    result valid for the granted requester
//   rsp_ready                 granted requester consumes the result
//   rsp_data                  captured ALU result, stable through RESP
//   alu_op/in1/in2            latched operation to the ALU
//   alu_enable                one-cycle ALU enable (ISSUE only)
//   alu_out                   ALU registered result
//   busy                      high in every state except IDLE
//   rsp_zero, rsp_sign        (ALU_ARB_FLAGS_EN) result flags
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [2:0]           req0_op,
   input  logic [WORD_SIZE-1:0] req0_a,
   input  logic [WORD_SIZE-1:0] req0_b,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [2:0]           req1_op,
   input  logic [WORD_SIZE-1:0] req1_a,
   input  logic [WORD_SIZE-1:0] req1_b,
   output logic                 rsp0_valid,
   output logic                 rsp1_valid,
   input  logic                 rsp_ready,
   output logic [WORD_SIZE-1:0] rsp_data,
   output logic [2:0]           alu_op,
   output logic [WORD_SIZE-1:0] alu_in1,
   output logic [WORD_SIZE-1:0] alu_in2,
   output logic                 alu_enable,
   input  logic [WORD_SIZE-1:0] alu_out,
   output logic                 busy
`ifdef ALU_ARB_FLAGS_EN
   ,
   output logic                 rsp_zero,
   output logic                 rsp_sign
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CAPT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic                   last_grant_q, last_grant_d;
   logic                   grant_q, grant_d;
   logic [2:0]             alu_op_q, alu_op_d;
   logic [WORD_SIZE-1:0]   alu_in1_q, alu_in1_d;
   logic [WORD_SIZE-1:0]   alu_in2_q, alu_in2_d;
   logic [WORD_SIZE-1:0]   rsp_data_q, rsp_data_d;
`ifdef ALU_ARB_FLAGS_EN
   logic                   rsp_zero_q, rsp_zero_d;
   logic                   rsp_sign_q, rsp_sign_d;
`endif

   // req1 wins when it is the only valid, or on a tie when req0 went last.
   logic pick1;
   logic any_valid;
   assign any_valid = req0_valid | req1_valid;
   assign pick1     = req1_valid & (~req0_valid | ~last_grant_q);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      alu_op_d     = alu_op_q;
      alu_in1_d    = alu_in1_q;
      alu_in2_d    = alu_in2_q;
      rsp_data_d   = rsp_data_q;
`ifdef ALU_ARB_FLAGS_EN
      rsp_zero_d   = rsp_zero_q;
      rsp_sign_d   = rsp_sign_q;
`endif
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      rsp0_valid   = 1'b0;
      rsp1_valid   = 1'b0;
      alu_enable   = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_valid) begin
               req0_ready   = ~pick1;
               req1_ready   = pick1;
               alu_op_d     = pick1 ? req1_op : req0_op;
               alu_in1_d    = pick1 ? req1_a  : req0_a;
               alu_in2_d    = pick1 ? req1_b  : req0_b;
               grant_d      = pick1;
               last_grant_d = pick1;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            // ALU registers its result at the end of this cycle.
            alu_enable = 1'b1;
            state_d    = CAPT;
         end
         CAPT: begin
            rsp_data_d = alu_out;
`ifdef ALU_ARB_FLAGS_EN
            rsp_zero_d = (alu_out == '0);
            rsp_sign_d = alu_out[WORD_SIZE-1];
`endif
            state_d    = RESP;
         end
         RESP: begin
            rsp0_valid = ~grant_q;
            rsp1_valid = grant_q;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;  // req0 wins the first tie
         grant_q      <= 1'b0;
         alu_op_q     <= '0;
         alu_in1_q    <= '0;
         alu_in2_q    <= '0;
         rsp_data_q   <= '0;
`ifdef ALU_ARB_FLAGS_EN
         rsp_zero_q   <= 1'b0;
         rsp_sign_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         alu_op_q     <= alu_op_d;
         alu_in1_q    <= alu_in1_d;
         alu_in2_q    <= alu_in2_d;
         rsp_data_q   <= rsp_data_d;
`ifdef ALU_ARB_FLAGS_EN
         rsp_zero_q   <= rsp_zero_d;
         rsp_sign_q   <= rsp_sign_d;
`endif
      end
   end

   assign alu_op   = alu_op_q;
   assign alu_in1  = alu_in1_q;
   assign alu_in2  = alu_in2_q;
   assign rsp_data = rsp_data_q;
   assign busy     = (state_q != IDLE);
`ifdef ALU_ARB_FLAGS_EN
   assign rsp_zero = rsp_zero_q;
   assign rsp_sign = rsp_sign_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Drives alu_arbiter with directed scenarios and a randomized phase, and
//   compares every cycle against a transaction timeline model: a request is
//   accepted in an idle cycle, the ALU is enabled one cycle later, the result
//   appears three cycles after acceptance and stays until consumed. A simple
//   registered ALU lives in the bench.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
   localparam int W = 16;
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2,
                          OP_OR  = 3'd3, OP_XOR = 3'd4, OP_SHIFT = 3'd5;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0]   req0_op, req1_op, alu_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp0_valid, rsp1_valid, rsp_ready, alu_enable, busy;
   logic [W-1:0] rsp_data, alu_in1, alu_in2, alu_out;
`ifdef ALU_ARB_FLAGS_EN
   logic         rsp_zero, rsp_sign;
`endif

   always #5 clk = ~clk;

   alu_arbiter #(.WORD_SIZE(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_enable(alu_enable), .alu_out(alu_out), .busy(busy)
`ifdef ALU_ARB_FLAGS_EN
      , .rsp_zero(rsp_zero), .rsp_sign(rsp_sign)
`endif
   );

   function automatic logic [W-1:0] alu_f(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
      case (op)
         OP_ADD:   return a + b;
         OP_SUB:   return a - b;
         OP_AND:   return a & b;
         OP_OR:    return a | b;
         OP_XOR:   return a ^ b;
         OP_SHIFT: return a << b[3:0];
         default:  return '0;
      endcase
   endfunction

   // External registered ALU.
   logic [W-1:0] alu_q;
   always @(posedge clk) begin
      if (rst) alu_q <= '0;
      else if (alu_enable) alu_q <= alu_f(alu_op, alu_in1, alu_in2);
   end
   assign alu_out = alu_q;

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h @%0t", tag, act, exp, $time);
      end
   endtask

   // Timeline model: m_age = cycles since acceptance (0 = nothing outstanding).
   int           m_age;
   bit           m_last, m_g;
   logic [2:0]   m_op;
   logic [W-1:0] m_a, m_b, m_res, m_rdata;
   bit           m_zero, m_sign;
   bit           acc0, acc1, last_en;
   int           cnt_acc, cnt_en, cnt_idle, cnt_rsp;

   task automatic model_reset();
      m_age = 0; m_last = 1'b1; m_g = 1'b0;
      m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_rdata = '0;
      m_zero = 1'b0; m_sign = 1'b0;
   endtask

   // One clock: check outputs mid-low-phase, step the model across the edge,
   // return at the next negedge so the caller can change inputs.
   task automatic cyc();
      bit v0, v1, g, have;
      #1;
      v0 = req0_valid; v1 = req1_valid; have = v0 | v1;
      if (v0 && v1) g = ~m_last; else g = v1;
      chk("busy",       busy,       m_age != 0);
      chk("req0_ready", req0_ready, m_age == 0 && have && !g);
      chk("req1_ready", req1_ready, m_age == 0 && have && g);
      chk("alu_enable", alu_enable, m_age == 1);
      chk("rsp0_valid", rsp0_valid, m_age == 3 && !m_g);
      chk("rsp1_valid", rsp1_valid, m_age == 3 && m_g);
      chk("rsp_data",   rsp_data,   m_rdata);
      chk("alu_op",     alu_op,     m_op);
      chk("alu_in1",    alu_in1,    m_a);
      chk("alu_in2",    alu_in2,    m_b);
`ifdef ALU_ARB_FLAGS_EN
      chk("rsp_zero",   rsp_zero,   m_zero);
      chk("rsp_sign",   rsp_sign,   m_sign);
`endif
      acc0 = !rst && m_age == 0 && have && !g;
      acc1 = !rst && m_age == 0 && have && g;
      last_en = alu_enable;
      cnt_acc  += int'(acc0 | acc1);
      cnt_en   += int'(alu_enable);
      cnt_idle += int'(!busy);
      cnt_rsp  += int'(!rst && m_age == 3 && rsp_ready);
      @(posedge clk);
      if (rst) model_reset();
      else begin
         case (m_age)
            0: if (have) begin
                  m_op  = g ? req1_op : req0_op;
                  m_a   = g ? req1_a  : req0_a;
                  m_b   = g ? req1_b  : req0_b;
                  m_res = alu_f(m_op, m_a, m_b);
                  m_g = g; m_last = g; m_age = 1;
               end
            1: m_age = 2;
            2: begin
                  m_rdata = m_res; m_zero = (m_res == 0); m_sign = m_res[W-1];
                  m_age = 3;
               end
            default: if (rsp_ready) m_age = 0;
         endcase
      end
      @(negedge clk);
   endtask

   // Run n cycles; requesters drop valid once accepted.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         if (acc0) req0_valid = 1'b0;
         if (acc1) req1_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      cyc();
      rst = 1'b0;
   endtask

   task automatic set0(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
   endtask
   task automatic set1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
   endtask

   int base;

   initial begin
      rst = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
      cnt_acc = 0; cnt_en = 0; cnt_idle = 0; cnt_rsp = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();

      // Reset state, then a single ADD on req0.
      do_reset();
      set0(OP_ADD, 3, 4); rsp_ready = 1'b1;   // rsp_ready ignored outside RESP
      cyc(); chk("s1_acc0", acc0, 1); req0_valid = 1'b0;
      cyc(); chk("s1_en_on", last_en, 1);
      cyc(); chk("s1_en_off", last_en, 0);
      #1;
      chk("s1_rsp0", rsp0_valid, 1); chk("s1_rsp1", rsp1_valid, 0);
      chk("s1_data", rsp_data, 16'd7);
      cyc();

      // Ties: req0 first after reset, then req1, then req0 again.
      do_reset();
      set0(OP_SUB, 10, 3); set1(OP_XOR, 16'hF0F0, 16'h0FF0); rsp_ready = 1'b1;
      cyc(); chk("s2_acc0", acc0, 1); req0_valid = 1'b0;
      cyc(); cyc(); #1 chk("s2_data0", rsp_data, 16'd7);
      cyc();
      cyc(); chk("s2_acc1", acc1, 1); req1_valid = 1'b0;
      cyc(); cyc(); #1 chk("s2_data1", rsp_data, 16'hFF00); chk("s2_rsp1", rsp1_valid, 1);
      cyc();
      set0(OP_AND, 16'h1234, 16'h00FF); set1(OP_OR, 1, 2);
      cyc(); chk("s2_tie2_acc0", acc0, 1); req0_valid = 1'b0;
      base = cnt_rsp;
      run(12);
      chk("s2_drain", cnt_rsp - base, 2);

      // Backpressure in RESP; req1 waits and is taken the IDLE cycle after.
      do_reset();
      set0(OP_ADD, 100, 23); rsp_ready = 1'b0;
      cyc(); req0_valid = 1'b0;
      cyc(); cyc();
      set1(OP_OR, 16'h00F0, 16'h000F);
      base = 0;
      for (int i = 0; i < 5; i++) begin cyc(); base += int'(acc1); end
      chk("s3_no_acc", base, 0);
      #1 chk("s3_rsp0", rsp0_valid, 1); chk("s3_data", rsp_data, 16'd123);
      rsp_ready = 1'b1;
      cyc(); chk("s3_acc_late", acc1, 0);
      cyc(); chk("s3_acc1", acc1, 1); req1_valid = 1'b0;
      run(4);

      // Reset while in CAPT: abort without a response.
      do_reset();
      set1(OP_AND, 16'hFFFF, 16'h0F0F); rsp_ready = 1'b1;
      cyc(); req1_valid = 1'b0;
      cyc();
      rst = 1'b1; cyc(); rst = 1'b0;
      #1 chk("s4_busy", busy, 0); chk("s4_data", rsp_data, 0); chk("s4_in1", alu_in1, 0);
      base = cnt_rsp;
      run(3);
      chk("s4_no_rsp", cnt_rsp - base, 0);
      set0(OP_OR, 16'h0A00, 16'h00B0);
      run(4); #1 chk("s4_data2", rsp_data, 16'h0AB0);
      run(2);
      chk("s4_done", cnt_rsp - base, 1);

`ifdef ALU_ARB_FLAGS_EN
      // Flags.
      do_reset();
      rsp_ready = 1'b1;
      set0(OP_SHIFT, 1, 15); run(3);
      #1 chk("s5_data", rsp_data, 16'h8000); chk("s5_sign", rsp_sign, 1); chk("s5_zero", rsp_zero, 0);
      run(1);
      set1(OP_SUB, 5, 5); run(3);
      #1 chk("s5_zero2", rsp_zero, 1); chk("s5_sign2", rsp_sign, 0);
      run(1);
`endif

      // Back-to-back req1: one accept per four cycles.
      do_reset();
      rsp_ready = 1'b1;
      set1(3'($urandom_range(0, 5)), W'($urandom), W'($urandom));
      cnt_acc = 0; cnt_en = 0; cnt_idle = 0;
      for (int i = 0; i < 16; i++) begin
         cyc();
         if (acc1) set1(3'($urandom_range(0, 5)), W'($urandom), W'($urandom));
      end
      req1_valid = 1'b0;
      chk("s6_accepts", cnt_acc, 4);
      chk("s6_en_duty", cnt_en, 4);
      chk("s6_idle", cnt_idle, 4);
      run(2);

      // Randomized traffic; requesters hold payload until accepted.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (!req0_valid && $urandom_range(0, 1) == 1)
            set0(3'($urandom_range(0, 5)), W'($urandom), W'($urandom));
         if (!req1_valid && $urandom_range(0, 1) == 1)
            set1(3'($urandom_range(0, 5)), W'($urandom), W'($urandom));
         rsp_ready = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 63) == 0);
         cyc();
         if (acc0) req0_valid = 1'b0;
         if (acc1) req1_valid = 1'b0;
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
